fetch_sequencer: RTL and testbench

- Sequences the instruction fetch stage: owns the program counter and the BROM/RAM execution select.
- Issues fetch addresses and waits out memory latency.
- Presents each instruction to the decode stage with a valid/ready handshake.
- Shares the single RAM address port between instruction fetch and a data-access requester.
- Sits between the fetch address/instruction mux datapath and the decode and execute stages.

---
 rtl/fetch_seq_pkg.sv | 36 +++
 rtl/fetch_ram_port_mux.sv | 19 +
 rtl/mux2_16.sv | 11 +
 rtl/fetch_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encoding, datapath widths and the latency-counter reload helper.
package fetch_seq_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 3;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [CNT_W-1:0]   lat_cnt_t;

  typedef enum logic [2:0] {
    ST_ISSUE   = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_VALID   = 3'd3,
    ST_DATA    = 3'd4
  } state_e;

  // Per-cycle control strobes decoded from the fetch state.
  typedef struct packed {
    logic capture;
    logic accept;
    logic load_cnt;
    logic dec_cnt;
    logic in_data;
  } fetch_ctl_t;

  // Counter value loaded when an access is launched; it counts the
  // remaining cycles until the memory read data is valid.
  function automatic lat_cnt_t lat_reload(input int unsigned latency);
    return lat_cnt_t'(latency - 1);
  endfunction

endpackage

// File: rtl/fetch_ram_port_mux.sv
// RAM address port arbitration: the data address wins the single RAM
// address port in any cycle where the data requester holds the grant.
module fetch_ram_port_mux
  import fetch_seq_pkg::*;
(
  input  logic  [ADDR_W-1:0] pc,
  input  logic  [ADDR_W-1:0] data_addr,
  input  logic               data_grant,
  output logic  [ADDR_W-1:0] ram_address
);

  mux2_16 u_mux (
    .sel (data_grant),
    .a   (pc),
    .b   (data_addr),
    .y   (ram_address)
  );

endmodule

// File: rtl/mux2_16.sv
// Generic 16-bit 2:1 multiplexer: y = sel ? b : a.
module mux2_16 (
  input  logic        sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, BROM/RAM select, latency wait, decode
// handshake and RAM port sharing. Optional counters: FETCH_SEQ_PERF_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter int unsigned       MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] ram_value,
  input  logic [INSTR_W-1:0] brom_value,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [ADDR_W-1:0]  brom_address,
  output logic [ADDR_W-1:0]  pc,
  output logic               execute_from_ram,
  output logic [INSTR_W-1:0] instruction_binary,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               jump_to_ram,
  input  logic               data_req,
  input  logic [ADDR_W-1:0]  data_addr,
  output logic               data_grant,
  output logic               data_rvalid
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        data_stall_count
`endif
);

  localparam lat_cnt_t LAT_LOAD = lat_reload(MEM_LATENCY);

  state_e     state_q, state_d;
  fetch_ctl_t ctl;

  lat_cnt_t   lat_cnt_q;
  addr_t      pc_q;
  logic       from_ram_q;
  instr_t     instr_q;
  logic       valid_q;

  logic       dpend_q;
  lat_cnt_t   dcnt_q;
  logic       drvalid_q;
  logic       grant;

  // While fetching from BROM the RAM port is idle and a data request is
  // served in any state; from RAM it only gets the ISSUE slot.
  always_comb begin
    grant = reset_n && data_req && !dpend_q &&
            (!from_ram_q || (state_q == ST_ISSUE));
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_d gets a default before any branch, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (jump_valid) begin
      state_d = ST_ISSUE;
    end else begin
      unique case (state_q)
        ST_ISSUE: begin
          if (from_ram_q && grant)  state_d = ST_DATA;
          else if (MEM_LATENCY == 1) state_d = ST_CAPTURE;
          else                       state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt_q <= lat_cnt_t'(1)) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: state_d = ST_VALID;
        ST_VALID: begin
          if (instr_ready) state_d = ST_ISSUE;
        end
        ST_DATA: begin
          if (drvalid_q) state_d = ST_ISSUE;
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------
  always_comb begin
    ctl          = '0;
    ctl.load_cnt = (state_q == ST_ISSUE);
    ctl.dec_cnt  = (state_q == ST_WAIT);
    ctl.capture  = (state_q == ST_CAPTURE) && !jump_valid;
    ctl.accept   = (state_q == ST_VALID) && valid_q && instr_ready;
    ctl.in_data  = (state_q == ST_DATA);
  end

  // ---------------------------------------------------------------------
  // Fetch datapath: PC, execution select, instruction register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      from_ram_q <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      lat_cnt_q  <= '0;
    end else begin
      // A jump replaces pc+1 even when it coincides with an accept.
      if (jump_valid) begin
        pc_q       <= jump_target;
        from_ram_q <= jump_to_ram;
      end else if (ctl.accept) begin
        pc_q <= pc_q + addr_t'(1);
      end

      if (jump_valid) begin
        valid_q <= 1'b0;
      end else if (ctl.capture) begin
        valid_q <= 1'b1;
      end else if (ctl.accept) begin
        valid_q <= 1'b0;
      end

      if (ctl.capture) begin
        instr_q <= from_ram_q ? ram_value : brom_value;
      end

      if (ctl.load_cnt) begin
        lat_cnt_q <= LAT_LOAD;
      end else if (ctl.dec_cnt) begin
        lat_cnt_q <= lat_cnt_q - lat_cnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data read tracker: one outstanding read, independent of jumps
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dpend_q   <= 1'b0;
      dcnt_q    <= '0;
      drvalid_q <= 1'b0;
    end else begin
      drvalid_q <= 1'b0;
      if (grant) begin
        if (MEM_LATENCY == 1) begin
          drvalid_q <= 1'b1;
        end else begin
          dpend_q <= 1'b1;
          dcnt_q  <= LAT_LOAD;
        end
      end else if (dpend_q) begin
        if (dcnt_q <= lat_cnt_t'(1)) begin
          drvalid_q <= 1'b1;
          dpend_q   <= 1'b0;
        end else begin
          dcnt_q <= dcnt_q - lat_cnt_t'(1);
        end
      end
    end
  end

  fetch_ram_port_mux u_ram_port_mux (
    .pc          (pc_q),
    .data_addr   (data_addr),
    .data_grant  (grant),
    .ram_address (ram_address)
  );

  assign brom_address       = pc_q;
  assign pc                 = pc_q;
  assign execute_from_ram   = from_ram_q;
  assign instruction_binary = instr_q;
  assign instr_valid        = valid_q;
  assign data_grant         = grant;
  assign data_rvalid        = drvalid_q;

`ifdef FETCH_SEQ_PERF_EN
  // Saturating event counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count      <= '0;
      data_stall_count <= '0;
    end else begin
      if (ctl.accept && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (ctl.in_data && (data_stall_count != 16'hFFFF)) begin
        data_stall_count <= data_stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (MEM_LATENCY=2) with
// latency-accurate BROM/RAM models and fetch/data scoreboards.
module tb_fetch_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          LAT      = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ram_value, brom_value;
  logic [15:0] ram_address, brom_address, pc;
  logic        execute_from_ram;
  logic [31:0] instruction_binary;
  logic        instr_valid, instr_ready;
  logic        jump_valid, jump_to_ram;
  logic [15:0] jump_target;
  logic        data_req;
  logic [15:0] data_addr;
  logic        data_grant, data_rvalid;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] fetch_count, data_stall_count;
`endif

  fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_LATENCY(LAT)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ram_value          (ram_value),
    .brom_value         (brom_value),
    .ram_address        (ram_address),
    .brom_address       (brom_address),
    .pc                 (pc),
    .execute_from_ram   (execute_from_ram),
    .instruction_binary (instruction_binary),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .jump_valid         (jump_valid),
    .jump_target        (jump_target),
    .jump_to_ram        (jump_to_ram),
    .data_req           (data_req),
    .data_addr          (data_addr),
    .data_grant         (data_grant),
    .data_rvalid        (data_rvalid)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .fetch_count        (fetch_count),
    .data_stall_count   (data_stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] brom_word(input logic [15:0] a);
    return (a == 16'h0000) ? 32'hDEADBEEF : {16'hB0B0, a};
  endfunction

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return {16'hCAFE, ~a};
  endfunction

  // Memories: data valid LAT cycles after the address is driven.
  logic [15:0] ram_pipe  [LAT];
  logic [15:0] brom_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0]  <= ram_address;
    brom_pipe[0] <= brom_address;
    for (int i = 1; i < LAT; i++) begin
      ram_pipe[i]  <= ram_pipe[i-1];
      brom_pipe[i] <= brom_pipe[i-1];
    end
  end
  assign ram_value  = ram_word(ram_pipe[LAT-1]);
  assign brom_value = brom_word(brom_pipe[LAT-1]);

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } fetch_exp_t;

  fetch_exp_t  fetch_q[$];
  logic [31:0] data_q[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int grant_cyc  = 0;
  int accepts    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [15:0] p, input logic [31:0] w);
    fetch_exp_t e;
    e.pc    = p;
    e.instr = w;
    fetch_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_within_bound", 32'(instr_valid), 32'd1);
  endtask

  task automatic accept_next(input logic [15:0] p, input logic [31:0] w);
    push_fetch(p, w);
    instr_ready = 1'b0;
    wait_valid();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (instr_valid && instr_ready) begin
        accepts++;
        check("fetch_q_occupancy", 32'(fetch_q.size() != 0), 32'd1);
        if (fetch_q.size() != 0) begin
          fetch_exp_t e;
          e = fetch_q.pop_front();
          check("accept_pc", 32'(pc), 32'(e.pc));
          check("accept_instr", instruction_binary, e.instr);
        end
      end
      if (data_rvalid) begin
        check("rvalid_latency", cyc - grant_cyc, 32'(LAT));
        check("data_q_occupancy", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) check("data_value", ram_value, data_q.pop_front());
      end
      if (data_grant) grant_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cycles;
    int first_valid;
    reset_n = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_target = '0;
    jump_to_ram = 1'b0; data_req = 1'b0; data_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'(RESET_PC));
    check("rst_brom_addr", 32'(brom_address), 32'(RESET_PC));
    check("rst_from_ram", 32'(execute_from_ram), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction_binary, 32'h0);
    check("rst_grant", 32'(data_grant), 32'd0);
    check("rst_rvalid", 32'(data_rvalid), 32'd0);

    // First fetch with instr_ready held high
    tick();
    instr_ready = 1'b1;
    push_fetch(16'h0000, 32'hDEADBEEF);
    reset_n = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!instr_valid && cycles < 20);
    check("first_valid_latency", cycles, 32'(LAT + 2));
    tick();
    instr_ready = 1'b0;
    check("pc_after_first", 32'(pc), 32'h0001);
    check("valid_after_first", 32'(instr_valid), 32'd0);

    // Back-pressure: hold instr_ready low for 5 cycles
    push_fetch(16'h0001, brom_word(16'h0001));
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_instr", instruction_binary, brom_word(16'h0001));
      check("hold_pc", 32'(pc), 32'h0001);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pc_after_hold", 32'(pc), 32'h0002);
    tick();
    check("pc_single_incr", 32'(pc), 32'h0002);

    // Jump into RAM during WAIT; in-flight BROM fetch is discarded
    jump_valid = 1'b1; jump_target = 16'h0100; jump_to_ram = 1'b1;
    tick();
    jump_valid = 1'b0;
    @(negedge clk);
    check("jump_ram_addr", 32'(ram_address), 32'h0100);
    check("jump_from_ram", 32'(execute_from_ram), 32'd1);
    check("jump_valid_clr", 32'(instr_valid), 32'd0);
    accept_next(16'h0100, ram_word(16'h0100));

    // RAM mode: data request takes the ISSUE slot
    data_req = 1'b1; data_addr = 16'h0200;
    data_q.push_back(ram_word(16'h0200));
    @(negedge clk);
    check("ram_grant", 32'(data_grant), 32'd1);
    check("ram_grant_addr", 32'(ram_address), 32'h0200);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    check("ram_grant_one_cycle", 32'(data_grant), 32'd0);
    check("ram_data_pc_hold", 32'(pc), 32'h0101);
    accept_next(16'h0101, ram_word(16'h0101));

    // BROM mode: data request during WAIT, fetch timing unchanged
    jump_valid = 1'b1; jump_target = 16'h0010; jump_to_ram = 1'b0;
    tick();
    jump_valid = 1'b0;
    push_fetch(16'h0010, brom_word(16'h0010));
    data_q.push_back(ram_word(16'h0300));
    first_valid = -1;
    for (int c = 0; c < 6; c++) begin
      data_req  = (c == 1);
      data_addr = 16'h0300;
      @(negedge clk);
      if (c == 1) begin
        check("brom_grant", 32'(data_grant), 32'd1);
        check("brom_grant_addr", 32'(ram_address), 32'h0300);
        check("brom_addr_pc", 32'(brom_address), 32'h0010);
      end
      if (instr_valid && first_valid < 0) first_valid = c;
      tick();
    end
    data_req = 1'b0;
    check("brom_fetch_timing", first_valid, 32'(LAT + 1));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // PC wrap and jump coinciding with accept
    jump_valid = 1'b1; jump_target = 16'hFFFF; jump_to_ram = 1'b0;
    tick();
    jump_valid = 1'b0;
    accept_next(16'hFFFF, brom_word(16'hFFFF));
    check("pc_wrap", 32'(pc), 32'h0000);
    push_fetch(16'h0000, 32'hDEADBEEF);
    wait_valid();
    instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 16'h0040; jump_to_ram = 1'b0;
    tick();
    instr_ready = 1'b0; jump_valid = 1'b0;
    check("jump_over_accept_pc", 32'(pc), 32'h0040);
    check("jump_over_accept_valid", 32'(instr_valid), 32'd0);
    accept_next(16'h0040, brom_word(16'h0040));
`ifdef FETCH_SEQ_PERF_EN
    check("perf_fetch_count", 32'(fetch_count), accepts);
    check("perf_stall_count", 32'(data_stall_count), 32'(LAT));
`endif

    // Jump during DATA: the outstanding read still completes
    jump_valid = 1'b1; jump_target = 16'h0050; jump_to_ram = 1'b1;
    tick();
    jump_valid = 1'b0;
    data_req = 1'b1; data_addr = 16'h0210;
    data_q.push_back(ram_word(16'h0210));
    @(negedge clk);
    check("data_jump_grant", 32'(data_grant), 32'd1);
    tick();
    data_req = 1'b0;
    jump_valid = 1'b1; jump_target = 16'h0060; jump_to_ram = 1'b1;
    tick();
    jump_valid = 1'b0;
    @(negedge clk);
    check("data_jump_pc", 32'(pc), 32'h0060);
    check("data_jump_rvalid", 32'(data_rvalid), 32'd1);
    accept_next(16'h0060, ram_word(16'h0060));

    // Reset while a data read is outstanding: read is dropped
    data_req = 1'b1; data_addr = 16'h0220;
    @(negedge clk);
    check("pre_reset_grant", 32'(data_grant), 32'd1);
    tick();
    data_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_pc", 32'(pc), 32'(RESET_PC));
    check("midrst_from_ram", 32'(execute_from_ram), 32'd0);
    check("midrst_instr", instruction_binary, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_rvalid", 32'(data_rvalid), 32'd0);
    end
    tick();
    reset_n = 1'b1;
    accept_next(16'h0000, 32'hDEADBEEF);
    repeat (4) tick();

    check("fetch_q_drained", fetch_q.size(), 32'd0);
    check("data_q_drained", data_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
